conv213_frame_encoder: RTL and testbench
========================================

Name: conv213_frame_encoder

Overview:
- Transmit-side framer for the (2,1,3) convolutional link.
- Accepts message bits over a valid/ready handshake and emits rate-1/2 code symbols for the eVITERBI_213 decoder.
- Appends K-1 zero tail bits after every BLOCK_LEN message bits, so each block ends in state 00.
- Asserts tb_en on the final tail symbol so the downstream decoder starts traceback on block boundaries.

Parameters:
BLOCK_LEN, 20, message bits per block; legal range 2..1024.
TAIL_LEN, 2, zero flush bits per block; fixed at K-1 = 2.
G0, 3'b111, generator polynomial for vx[1]: 1+D+D^2.
G1, 3'b101, generator polynomial for vx[0]: 1+D^2.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high reset.
u_valid  input  1  ux carries a valid message bit.
ux  input  1  message bit.
u_ready  output  1  encoder accepts ux this cycle.
vx  output  2  code symbol {g0 out, g1 out}.
vx_valid  output  1  vx is valid this cycle.
tb_en  output  1  one-cycle pulse coincident with the last symbol of a block.
block_start  output  1  one-cycle pulse coincident with the first symbol of a block.

Behaviour:
- Reset and reset values:
  - One clock; reset is asynchronous and active-high.
  - While reset is high: state=IDLE, shift register s={s1,s2}=00, bit counter=0, tail counter=0, vx=00, vx_valid=0, tb_en=0, block_start=0.
  - u_ready is combinational from state and equals 0 during reset.
- Encoding:
  - v1 = u^s1^s2 (G0); v0 = u^s2 (G1); vx <= {v1,v0}.
  - After each encoded bit: s1 <= u, s2 <= old s1.
- Handshake:
  - A bit is accepted when u_valid && u_ready at a rising edge.
  - Latency: the corresponding vx/vx_valid is registered and appears in the next cycle.
  - One symbol is produced per accepted or tail bit; no other symbols.
- Output holding:
  - vx_valid=0 on any cycle where no bit was accepted or shifted; vx holds its last value.
  - tb_en and block_start are 0 whenever vx_valid is 0.
- State machine:
  - IDLE:
    - u_ready=1; s=00.
    - On accept: encode the bit, set block_start next cycle, bit counter=1, go to DATA.
  - DATA:
    - u_ready=1.
    - On accept: encode, increment the bit counter.
    - When the accepted bit is the BLOCK_LEN-th: go to TAIL, tail counter=0.
    - u_valid low: stall; state, s and counters hold.
  - TAIL:
    - u_ready=0.
    - Each cycle encode u=0 unconditionally (no stall), increment the tail counter.
    - On the TAIL_LEN-th tail bit: tb_en asserts next cycle together with that symbol; s returns to 00; go to IDLE.
- Block framing:
  - Exactly BLOCK_LEN+TAIL_LEN valid symbols per block.
  - Back-to-back blocks: IDLE accepts immediately, so the only bubble between blocks is the TAIL_LEN cycles with u_ready=0.
- Counter widths: clog2(BLOCK_LEN+1) bits for the bit counter, 2 bits for the tail counter; no wrap inside a block.
- Reset mid-block:
  - The partial block is discarded; there is no tail and no tb_en.
  - The first accepted bit after reset deassertion starts a new block with block_start.

Test Plan:
- Reset: assert reset mid-cycle, no clock edge → all outputs 0 immediately; u_ready=0. Release → u_ready=1, vx_valid=0.
- Impulse, BLOCK_LEN=20: bit 1 followed by 19 zeros, u_valid held high:
  - vx sequence 11,10,11 then 00 for the remaining 19 symbols, 22 symbols total.
  - block_start on symbol 1; tb_en only on symbol 22.
- Known vector, BLOCK_LEN=4: u=1,0,1,1 (MSB first):
  - vx = 11,10,00,01 then tail 01,11.
  - u_ready=0 for exactly 2 cycles; tb_en on the 6th symbol.
- Stalls: same BLOCK_LEN=4 vector with u_valid low for 3 cycles between bits 2 and 3 → identical symbol sequence; vx_valid=0 and vx held during the gaps.
- Back-to-back: 10 blocks of 20 bits, u_valid always high:
  - 220 valid symbols total; 10 tb_en pulses spaced 22 cycles apart.
  - Decoder Dx matches the input blocks.
- Reset at bit 7 of a 20-bit block, then a full block → no tb_en for the aborted block; the new block produces 22 symbols starting from state 00.

Source files
------------

// File: rtl/conv213_frame_encoder_if.sv
// rtl/conv213_frame_encoder_if.sv - message-in / symbol-out bundle for the (2,1,3) framer
interface conv213_frame_encoder_if;
  logic       u_valid;
  logic       ux;
  logic       u_ready;
  logic [1:0] vx;
  logic       vx_valid;
  logic       tb_en;
  logic       block_start;

  // master: bit source that also observes the symbol stream
  modport master (
    output u_valid,
    output ux,
    input  u_ready,
    input  vx,
    input  vx_valid,
    input  tb_en,
    input  block_start
  );

  // slave: the encoder itself
  modport slave (
    input  u_valid,
    input  ux,
    output u_ready,
    output vx,
    output vx_valid,
    output tb_en,
    output block_start
  );
endinterface

// File: rtl/conv213_frame_encoder.sv
// rtl/conv213_frame_encoder.sv - rate-1/2 (2,1,3) convolutional framer with zero-tail block termination
module conv213_frame_encoder #(
  parameter int         BLOCK_LEN = 20,
  parameter int         TAIL_LEN  = 2,
  parameter logic [2:0] G0        = 3'b111,
  parameter logic [2:0] G1        = 3'b101
) (
  input logic                    clock,
  input logic                    reset,
  conv213_frame_encoder_if.slave bus
);

  localparam int            BW        = $clog2(BLOCK_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(BLOCK_LEN - 1);
  localparam logic [BW-1:0] ONE_BIT   = BW'(1);
  localparam logic [1:0]    LAST_TAIL = 2'(TAIL_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_s1;
  logic          r_s2;
  logic [BW-1:0] r_bit_cnt;
  logic [1:0]    r_tail_cnt;
  logic [1:0]    r_vx;
  logic          r_vx_valid;
  logic          r_tb_en;
  logic          r_block_start;

  logic          w_ready;
  logic          w_accept;
  logic          w_shift;
  logic          w_u;
  logic [BW-1:0] w_bit_cnt_nxt;
  logic [1:0]    w_tail_cnt_nxt;
  logic          w_tb_en_nxt;
  logic          w_block_start_nxt;
  logic          w_s1_nxt;
  logic          w_s2_nxt;
  logic [1:0]    w_vx_nxt;
  logic          w_vx_valid_nxt;
  logic [2:0]    w_taps;

  // Ready depends only on state; forced low while reset is held so nothing is accepted mid-reset.
  assign w_ready  = !reset && (r_state != S_TAIL);
  assign w_accept = bus.u_valid && w_ready;

  // FSM next-state: decides whether a bit shifts this cycle and which one, plus framing flags.
  always_comb begin
    w_state_nxt       = r_state;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_tail_cnt_nxt    = r_tail_cnt;
    w_shift           = 1'b0;
    w_u               = 1'b0;
    w_tb_en_nxt       = 1'b0;
    w_block_start_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shift           = 1'b1;
          w_u               = bus.ux;
          w_block_start_nxt = 1'b1;
          w_bit_cnt_nxt     = ONE_BIT;
          w_state_nxt       = S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_shift       = 1'b1;
          w_u           = bus.ux;
          w_bit_cnt_nxt = r_bit_cnt + ONE_BIT;
          if (r_bit_cnt == LAST_BIT) begin
            w_tail_cnt_nxt = 2'd0;
            w_state_nxt    = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        // Flush zeros without stalling so the block always closes in state 00.
        w_shift        = 1'b1;
        w_u            = 1'b0;
        w_tail_cnt_nxt = r_tail_cnt + 2'd1;
        if (r_tail_cnt == LAST_TAIL) begin
          w_tb_en_nxt    = 1'b1;
          w_tail_cnt_nxt = 2'd0;
          w_bit_cnt_nxt  = '0;
          w_state_nxt    = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Encoder datapath: generator taps over {u, s1, s2}; vx holds when nothing shifts.
  always_comb begin
    w_taps         = {w_u, r_s1, r_s2};
    w_s1_nxt       = r_s1;
    w_s2_nxt       = r_s2;
    w_vx_nxt       = r_vx;
    w_vx_valid_nxt = 1'b0;
    if (w_shift) begin
      w_vx_nxt       = {^(G0 & w_taps), ^(G1 & w_taps)};
      w_vx_valid_nxt = 1'b1;
      w_s1_nxt       = w_u;
      w_s2_nxt       = r_s1;
    end
  end

  // State, shift register, counters and registered symbol outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_bit_cnt     <= '0;
      r_tail_cnt    <= 2'd0;
      r_vx          <= 2'b00;
      r_vx_valid    <= 1'b0;
      r_tb_en       <= 1'b0;
      r_block_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_s1          <= w_s1_nxt;
      r_s2          <= w_s2_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_tail_cnt    <= w_tail_cnt_nxt;
      r_vx          <= w_vx_nxt;
      r_vx_valid    <= w_vx_valid_nxt;
      r_tb_en       <= w_tb_en_nxt;
      r_block_start <= w_block_start_nxt;
    end
  end

  assign bus.u_ready     = w_ready;
  assign bus.vx          = r_vx;
  assign bus.vx_valid    = r_vx_valid;
  assign bus.tb_en       = r_tb_en;
  assign bus.block_start = r_block_start;

endmodule

// File: tb/tb_conv213_frame_encoder.sv
// tb/tb_conv213_frame_encoder.sv - self-checking bench for conv213_frame_encoder
module tb_conv213_frame_encoder;
  localparam int TAIL = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tb_uv[2];
  logic tb_ux[2];

  int checks   = 0;
  int failures = 0;

  conv213_frame_encoder_if if20 ();
  conv213_frame_encoder_if if4 ();

  assign if20.u_valid = tb_uv[0];
  assign if20.ux      = tb_ux[0];
  assign if4.u_valid  = tb_uv[1];
  assign if4.ux       = tb_ux[1];

  conv213_frame_encoder #(.BLOCK_LEN(20)) dut20 (.clock(clock), .reset(reset), .bus(if20));
  conv213_frame_encoder #(.BLOCK_LEN(4))  dut4  (.clock(clock), .reset(reset), .bus(if4));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: per block keep the message bits; symbol k is the
  // convolution of bits k, k-1, k-2 with zeros outside 0..BLOCK_LEN-1.
  int       blen[2] = '{20, 4};
  bit       mblk[2][0:1023];
  int       mcnt[2];
  int       mtail[2];
  bit [1:0] e_vx[2];
  bit       e_vv[2];
  bit       e_tb[2];
  bit       e_bs[2];
  int       mk;

  function automatic bit mbit(input int d, input int k);
    if (k < 0 || k >= blen[d]) return 1'b0;
    return mblk[d][k];
  endfunction

  function automatic bit [1:0] msym(input int d, input int k);
    bit u, a, b;
    u = mbit(d, k);
    a = mbit(d, k - 1);
    b = mbit(d, k - 2);
    return {u ^ a ^ b, u ^ b};
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        mcnt[d]  = 0;
        mtail[d] = 0;
        e_vx[d]  = 2'b00;
        e_vv[d]  = 1'b0;
        e_tb[d]  = 1'b0;
        e_bs[d]  = 1'b0;
      end else begin
        e_vv[d] = 1'b0;
        e_tb[d] = 1'b0;
        e_bs[d] = 1'b0;
        if (mtail[d] > 0) begin
          mk      = blen[d] + TAIL - mtail[d];
          e_vx[d] = msym(d, mk);
          e_vv[d] = 1'b1;
          mtail[d]--;
          if (mtail[d] == 0) begin
            e_tb[d] = 1'b1;
            mcnt[d] = 0;
          end
        end else if (tb_uv[d]) begin
          mblk[d][mcnt[d]] = tb_ux[d];
          e_vx[d] = msym(d, mcnt[d]);
          e_vv[d] = 1'b1;
          e_bs[d] = (mcnt[d] == 0);
          mcnt[d]++;
          if (mcnt[d] == blen[d]) mtail[d] = TAIL;
        end
      end
    end
  end

  function automatic logic [5:0] dut_out(input int d);
    if (d == 0) return {if20.u_ready, if20.vx, if20.vx_valid, if20.tb_en, if20.block_start};
    return {if4.u_ready, if4.vx, if4.vx_valid, if4.tb_en, if4.block_start};
  endfunction

  // Compare process plus symbol logs for the literal checks.
  int         cyc = 0;
  logic [3:0] logq[2][$];
  int         tbc[$];
  int         tbcount[2];
  int         nready4 = 0;
  logic [5:0] o;

  always @(negedge clock) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      o = dut_out(d);
      check($sformatf("d%0d u_ready", d),     32'(o[5]),   32'(!reset && mtail[d] == 0));
      check($sformatf("d%0d vx", d),          32'(o[4:3]), 32'(e_vx[d]));
      check($sformatf("d%0d vx_valid", d),    32'(o[2]),   32'(e_vv[d]));
      check($sformatf("d%0d tb_en", d),       32'(o[1]),   32'(e_tb[d]));
      check($sformatf("d%0d block_start", d), 32'(o[0]),   32'(e_bs[d]));
      if (o[2] === 1'b1) logq[d].push_back({o[4:3], o[1], o[0]});
      if (o[1] === 1'b1) begin
        tbcount[d]++;
        if (d == 0) tbc.push_back(cyc);
      end
      if (d == 1 && !reset && o[5] !== 1'b1) nready4++;
    end
  end

  task automatic send_bit(input int d, input logic b);
    logic rdy;
    int   n;
    n = 0;
    tb_uv[d] = 1'b1;
    tb_ux[d] = b;
    forever begin
      @(negedge clock);
      rdy = (d == 0) ? if20.u_ready : if4.u_ready;
      @(posedge clock);
      #2;
      if (rdy === 1'b1) break;
      n++;
      if (n > 10) begin
        check("send_bit ready timeout", 32'(rdy), 32'(1));
        break;
      end
    end
  endtask

  task automatic idle(input int d, input int n);
    tb_uv[d] = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  logic [3:0] exp_vec[6] = '{4'b1101, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b1110};
  logic       vec_bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [3:0] exp_imp;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tb_uv[0] = 1'b0; tb_uv[1] = 1'b0;
    tb_ux[0] = 1'b0; tb_ux[1] = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    check("release u_ready", 32'(if20.u_ready), 32'(1));
    check("release vx_valid", 32'(if20.vx_valid), 32'(0));
    @(posedge clock);
    #2;

    // Reset asserted mid-cycle while a block is active: outputs clear without a clock edge.
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    tb_uv[0] = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("async rst vx", 32'(if20.vx), 32'(0));
    check("async rst vx_valid", 32'(if20.vx_valid), 32'(0));
    check("async rst block_start", 32'(if20.block_start), 32'(0));
    check("async rst u_ready", 32'(if20.u_ready), 32'(0));
    @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    check("rerelease u_ready", 32'(if20.u_ready), 32'(1));
    check("rerelease vx_valid", 32'(if20.vx_valid), 32'(0));
    @(posedge clock);
    #2;

    // Impulse through the 20-bit framer.
    logq[0].delete();
    send_bit(0, 1'b1);
    for (int i = 0; i < 19; i++) send_bit(0, 1'b0);
    idle(0, 6);
    check("impulse count", 32'(logq[0].size()), 32'(22));
    for (int i = 0; i < 22; i++) begin
      exp_imp = (i == 0) ? 4'b1101 : (i == 1) ? 4'b1000 : (i == 2) ? 4'b1100 :
                (i == 21) ? 4'b0010 : 4'b0000;
      check($sformatf("impulse sym%0d", i), 32'(logq[0][i]), 32'(exp_imp));
    end

    // Known vector through the 4-bit framer.
    logq[1].delete();
    nready4 = 0;
    for (int i = 0; i < 4; i++) send_bit(1, vec_bits[i]);
    idle(1, 6);
    check("vector count", 32'(logq[1].size()), 32'(6));
    for (int i = 0; i < 6; i++) check($sformatf("vector sym%0d", i), 32'(logq[1][i]), 32'(exp_vec[i]));
    check("vector not-ready cycles", 32'(nready4), 32'(2));

    // Same vector with a 3-cycle stall between bits 2 and 3.
    logq[1].delete();
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    idle(1, 3);
    send_bit(1, 1'b1);
    send_bit(1, 1'b1);
    idle(1, 6);
    check("stall count", 32'(logq[1].size()), 32'(6));
    for (int i = 0; i < 6; i++) check($sformatf("stall sym%0d", i), 32'(logq[1][i]), 32'(exp_vec[i]));

    // Ten back-to-back 20-bit blocks with u_valid held high.
    logq[0].delete();
    tbc.delete();
    for (int blk = 0; blk < 10; blk++)
      for (int i = 0; i < 20; i++) send_bit(0, 1'($urandom_range(0, 1)));
    idle(0, 6);
    check("b2b symbols", 32'(logq[0].size()), 32'(220));
    check("b2b tb_en pulses", 32'(tbc.size()), 32'(10));
    for (int i = 1; i < tbc.size(); i++)
      check($sformatf("b2b tb_en spacing%0d", i), 32'(tbc[i] - tbc[i-1]), 32'(22));

    // Reset at bit 7 of a block, then a complete block from state 00.
    tbcount[0] = 0;
    for (int i = 0; i < 7; i++) send_bit(0, 1'(i % 2));
    tb_uv[0] = 1'b0;
    #1;
    reset = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    idle(0, 2);
    check("aborted block tb_en", 32'(tbcount[0]), 32'(0));
    logq[0].delete();
    send_bit(0, 1'b1);
    for (int i = 1; i < 20; i++) send_bit(0, 1'($urandom_range(0, 1)));
    idle(0, 6);
    check("post-reset count", 32'(logq[0].size()), 32'(22));
    check("post-reset first sym", 32'(logq[0][0]), 32'(4'b1101));
    check("post-reset last tb_en", 32'(logq[0][21][1]), 32'(1));
    check("post-reset tb_en pulses", 32'(tbcount[0]), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
